// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the register file: clear FSM states,
// address-width helper and the byte-lane merge used by writes and bypass.
package reg_file_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Widest word the lane merge handles; callers size-cast into and out of it.
  localparam int MERGE_MAX = 1024;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [MERGE_MAX-1:0] lane_merge(
    input logic [MERGE_MAX-1:0]   old_word,
    input logic [MERGE_MAX-1:0]   new_word,
    input logic [MERGE_MAX/8-1:0] lanes
  );
    logic [MERGE_MAX-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MERGE_MAX / 8; i++) begin
      if (lanes[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/register_file_clear_fsm.sv
// Clear sequencer: walks every entry once, one per cycle, after a clear request.
//   state | meaning
//   IDLE  | normal operation, waiting for clearReq
//   CLEAR | zeroing entry[cnt] on each edge, busy high
module register_file_clear_fsm
  import reg_file_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int AW    = addr_width(DEPTH)
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          clearReq,
  output logic          busy,
  output logic          clrEn,
  output logic [AW-1:0] clrAddr
);

  clr_state_e    state;
  logic [AW-1:0] cnt;
  logic          last_entry;

  assign last_entry = (cnt == AW'(DEPTH - 1));

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clearReq) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          if (last_entry) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy    = (state == CLEAR);
  assign clrEn   = (state == CLEAR);
  assign clrAddr = cnt;

endmodule

// File: rtl/register_file.sv
// Multi-port register file: one byte-enabled write port, two registered read
// ports with same-cycle write bypass, optional hard-wired zero entry, clear sequencer.
module register_file
  import reg_file_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  bit ZERO_REG = 1'b1,
  localparam int AW       = addr_width(DEPTH)
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               writeEn,
  input  logic [AW-1:0]      wrAddr,
  input  logic [WIDTH-1:0]   wrData,
  input  logic [WIDTH/8-1:0] byteEn,
  input  logic [AW-1:0]      rdAddrA,
  output logic [WIDTH-1:0]   rdDataA,
  input  logic [AW-1:0]      rdAddrB,
  output logic [WIDTH-1:0]   rdDataB,
  input  logic               clearReq,
  output logic               busy
);

  if ((WIDTH % 8) != 0 || WIDTH >= MERGE_MAX || DEPTH < 2 || (1 << AW) != DEPTH) begin : g_param_check
    $error("register_file: WIDTH must be a multiple of 8 below MERGE_MAX, DEPTH a power of 2 >= 2");
  end

  logic [WIDTH-1:0]     mem [DEPTH];
  logic                 clr_en;
  logic [AW-1:0]        clr_addr;
  logic                 wr_fire;
  logic [MERGE_MAX-1:0] merge_wide;
  logic [WIDTH-1:0]     merged_wr;
  logic                 unused_merge_hi;
  logic [WIDTH-1:0]     next_a;
  logic [WIDTH-1:0]     next_b;

  register_file_clear_fsm #(.DEPTH(DEPTH)) u_clear_fsm (
    .CLK      (CLK),
    .reset    (reset),
    .clearReq (clearReq),
    .busy     (busy),
    .clrEn    (clr_en),
    .clrAddr  (clr_addr)
  );

  // A write in the clearReq cycle is dropped, and nothing lands while clearing.
  assign wr_fire = !busy && writeEn && !clearReq && !(ZERO_REG && (wrAddr == '0));

  assign merge_wide      = lane_merge(MERGE_MAX'(mem[wrAddr]), MERGE_MAX'(wrData), (MERGE_MAX/8)'(byteEn));
  assign merged_wr       = merge_wide[WIDTH-1:0];
  assign unused_merge_hi = ^merge_wide[MERGE_MAX-1:WIDTH];

  // wr_fire is never set during CLEAR, so the clear walk reads without bypass.
  always_comb begin
    next_a = mem[rdAddrA];
    if (ZERO_REG && (rdAddrA == '0))            next_a = '0;
    else if (wr_fire && (wrAddr == rdAddrA))    next_a = merged_wr;

    next_b = mem[rdAddrB];
    if (ZERO_REG && (rdAddrB == '0))            next_b = '0;
    else if (wr_fire && (wrAddr == rdAddrB))    next_b = merged_wr;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdDataA <= '0;
      rdDataB <= '0;
    end else begin
      if (clr_en)       mem[clr_addr] <= '0;
      else if (wr_fire) mem[wrAddr]   <= merged_wr;
      rdDataA <= next_a;
      rdDataB <= next_b;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table, clear/reset
// sequences and randomized traffic against a behavioural model.
module tb_register_file;

  localparam int DEPTH = 32;

  logic        CLK = 1'b0;
  logic        reset;
  logic        writeEn;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [3:0]  byteEn;
  logic [4:0]  rdAddrA;
  logic [31:0] rdDataA;
  logic [4:0]  rdAddrB;
  logic [31:0] rdDataB;
  logic        clearReq;
  logic        busy;

  always #5 CLK = ~CLK;

  register_file #(.WIDTH(32), .DEPTH(DEPTH), .ZERO_REG(1'b1)) dut (
    .CLK      (CLK),
    .reset    (reset),
    .writeEn  (writeEn),
    .wrAddr   (wrAddr),
    .wrData   (wrData),
    .byteEn   (byteEn),
    .rdAddrA  (rdAddrA),
    .rdDataA  (rdDataA),
    .rdAddrB  (rdAddrB),
    .rdDataB  (rdDataB),
    .clearReq (clearReq),
    .busy     (busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: plain array plus "cycles of clearing left" bookkeeping.
  logic [31:0] model [DEPTH];
  int          clr_left;
  int          clr_idx;
  logic [31:0] exp_a, exp_b;
  logic        exp_busy;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        clr;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ebusy;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [31:0] bmerge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    clr_left = 0;
    clr_idx  = 0;
  endtask

  // Drive one cycle, advance model at the edge, leave time at edge+1.
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input logic [4:0] ra, input logic [4:0] rb,
                      input logic clr);
    logic idle, wr_ok;
    writeEn = we; wrAddr = wa; wrData = wd; byteEn = be;
    rdAddrA = ra; rdAddrB = rb; clearReq = clr;
    idle  = (clr_left == 0);
    wr_ok = idle && we && !clr && (wa != 5'd0);
    exp_a = (ra == 5'd0) ? 32'h0 : (wr_ok && wa == ra) ? bmerge(model[ra], wd, be) : model[ra];
    exp_b = (rb == 5'd0) ? 32'h0 : (wr_ok && wa == rb) ? bmerge(model[rb], wd, be) : model[rb];
    @(posedge CLK);
    if (!idle) begin
      model[clr_idx] = '0;
      clr_idx++;
      clr_left--;
    end else if (clr) begin
      clr_left = DEPTH;
      clr_idx  = 0;
    end else if (wr_ok) begin
      model[wa] = bmerge(model[wa], wd, be);
    end
    exp_busy = (clr_left > 0);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_a"}, rdDataA, exp_a);
    check({tag, "_b"}, rdDataB, exp_b);
    check({tag, "_busy"}, {31'b0, busy}, {31'b0, exp_busy});
  endtask

  // Counts cycles busy is seen high, starting from a cycle where it was just raised.
  task automatic count_busy(input string tag, output int n);
    n = 1;
    for (int c = 1; c <= 40 && busy; c++) begin
      if (c == 20) step(1'b1, 5'd2, 32'h55555555, 4'hF, 5'd31, 5'd2, 1'b1);
      else         step(1'b0, 5'd0, 32'h0, 4'h0, 5'd31, 5'(c % 32), 1'b0);
      check_model(tag);
      if (c == 10) check({tag, "_entry31_mid"}, rdDataA, 32'd31);
      if (busy) n++;
    end
  endtask

  initial begin
    int n;

    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd5, 5'd0, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[1] = '{1'b1, 5'd5, 32'h11223344, 4'h5, 5'd5, 5'd5, 1'b0, 32'hDE22BE44, 32'hDE22BE44, 1'b0};
    vecs[2] = '{1'b0, 5'd0, 32'h0,        4'h0, 5'd5, 5'd7, 1'b0, 32'hDE22BE44, 32'h0, 1'b0};
    vecs[3] = '{1'b1, 5'd7, 32'hCAFEF00D, 4'hF, 5'd7, 5'd7, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
    vecs[4] = '{1'b1, 5'd7, 32'hFFFFFFFF, 4'hF, 5'd7, 5'd5, 1'b0, 32'hFFFFFFFF, 32'hDE22BE44, 1'b0};
    vecs[5] = '{1'b1, 5'd7, 32'hCAFEF00D, 4'h3, 5'd7, 5'd7, 1'b0, 32'hFFFFF00D, 32'hFFFFF00D, 1'b0};
    vecs[6] = '{1'b1, 5'd0, 32'h12345678, 4'hF, 5'd0, 5'd7, 1'b0, 32'h0, 32'hFFFFF00D, 1'b0};
    vecs[7] = '{1'b0, 5'd0, 32'h0,        4'h0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[8] = '{1'b1, 5'd9, 32'hAAAAAAAA, 4'h0, 5'd9, 5'd9, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[9] = '{1'b0, 5'd0, 32'h0,        4'h0, 5'd9, 5'd5, 1'b0, 32'h0, 32'hDE22BE44, 1'b0};

    reset = 1'b0;
    writeEn = 1'b0; wrAddr = '0; wrData = '0; byteEn = '0;
    rdAddrA = '0; rdAddrB = '0; clearReq = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("reset_rdA", rdDataA, 32'h0);
    check("reset_rdB", rdDataB, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    @(negedge CLK);
    reset = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 5'd0, 32'h0, 4'h0, 5'(i), 5'(DEPTH - 1 - i), 1'b0);
      check("reset_read_a", rdDataA, 32'h0);
      check("reset_read_b", rdDataB, 32'h0);
    end

    for (int v = 0; v < 10; v++) begin
      step(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].be, vecs[v].ra, vecs[v].rb, vecs[v].clr);
      check($sformatf("vec%0d_a", v), rdDataA, vecs[v].ea);
      check($sformatf("vec%0d_b", v), rdDataB, vecs[v].eb);
      check($sformatf("vec%0d_busy", v), {31'b0, busy}, {31'b0, vecs[v].ebusy});
    end

    // Full clear after filling each entry with its index.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 5'(i), 32'(i), 4'hF, 5'd0, 5'd0, 1'b0);
    step(1'b1, 5'd3, 32'hFFFFFFFF, 4'hF, 5'd3, 5'd31, 1'b1);
    check("clear_drop_write", rdDataA, 32'd3);
    check("clear_start_b", rdDataB, 32'd31);
    check("clear_busy_rise", {31'b0, busy}, 32'h1);
    count_busy("clear", n);
    check("clear_busy_len", 32'(n), 32'd32);
    step(1'b1, 5'd4, 32'h0BADF00D, 4'hF, 5'd4, 5'd2, 1'b0);
    check("first_write_after_clear", rdDataA, 32'h0BADF00D);
    check("ignored_write_in_clear", rdDataB, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 5'd0, 32'h0, 4'h0, 5'(i), 5'(DEPTH - 1 - i), 1'b0);
      check_model("post_clear");
      if (i != 4) check("post_clear_zero", rdDataA, 32'h0);
    end

    // Reset in the middle of a clear.
    step(1'b1, 5'd20, 32'h20202020, 4'hF, 5'd0, 5'd0, 1'b0);
    step(1'b1, 5'd30, 32'h30303030, 4'hF, 5'd0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 4'h0, 5'd20, 5'd30, 1'b1);
    for (int c = 0; c < 5; c++) step(1'b0, 5'd0, 32'h0, 4'h0, 5'd20, 5'd30, 1'b0);
    check("pre_abort_busy", {31'b0, busy}, 32'h1);
    check("pre_abort_a", rdDataA, 32'h20202020);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_rdA", rdDataA, 32'h0);
    check("abort_rdB", rdDataB, 32'h0);
    model_reset();
    @(negedge CLK);
    reset = 1'b1;
    step(1'b0, 5'd0, 32'h0, 4'h0, 5'd20, 5'd30, 1'b0);
    check("abort_entry20", rdDataA, 32'h0);
    check("abort_entry30", rdDataB, 32'h0);
    for (int i = 1; i < DEPTH; i++) step(1'b1, 5'(i), 32'(i), 4'hF, 5'd0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1'b1);
    check("reclear_busy_rise", {31'b0, busy}, 32'h1);
    count_busy("reclear", n);
    check("reclear_busy_len", 32'(n), 32'd32);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      logic [4:0] wa, ra, rb;
      wa = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)), ra, rb,
           ($urandom_range(0, 79) == 0));
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-port register file succeeding the single 32-bit write-enabled register in the processor datapath. Provides one byte-enabled write port, two registered read ports with write-to-read bypass, an optional hard-wired zero entry, and a run-time clear sequencer that flushes every entry, one per cycle. Sits between decode (read addresses) and write-back (write port) in the 32-bit processor core.

## Interface
- WIDTH, 32, data width in bits; multiple of 8
- DEPTH, 32, number of entries; power of 2, at least 2
- ZERO_REG, 1, when 1, entry 0 always reads 0 and ignores writes
- CLK  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- writeEn  in  1  write enable
- wrAddr  in  log2(DEPTH)  write address
- wrData  in  WIDTH  write data
- byteEn  in  WIDTH/8  per-byte write lane enable; bit i covers wrData[8i+7:8i]
- rdAddrA  in  log2(DEPTH)  read port A address
- rdDataA  out  WIDTH  read port A data, registered
- rdAddrB  in  log2(DEPTH)  read port B address
- rdDataB  out  WIDTH  read port B data, registered
- clearReq  in  1  single-cycle request to start a full clear
- busy  out  1  high while the clear sequence runs

## Operation
- Reset (reset low, asynchronous): all entries 0, rdDataA/rdDataB 0, busy 0, state IDLE, clear counter 0.
- Write: in IDLE, writeEn high and clearReq low updates only the lanes of entry[wrAddr] with byteEn bit set. byteEn all-zero is a no-op.
- ZERO_REG=1: writes to address 0 are discarded. Reads of address 0 return 0, including bypass.
- Read: each port samples its address every cycle. rdDataX is the entry value the following cycle.
- Bypass, IDLE only: a write in the same cycle to the read address makes rdDataX show the merged value. Enabled lanes come from wrData; the other lanes keep the stored value. Both ports bypass independently.
- Clear FSM states: IDLE, CLEAR.
- IDLE -> CLEAR when clearReq is sampled high. Any write in that cycle is dropped. Counter set to 0.
- In CLEAR, each edge zeroes entry[cnt] and increments cnt. When cnt = DEPTH-1, that entry is zeroed and the FSM returns to IDLE.
- In CLEAR, writeEn and clearReq are ignored. Reads continue from the array without bypass, so entries not yet cleared return their old contents.
- Reset during CLEAR aborts the sequence: IDLE, busy 0, all entries 0.

## Timing
- Read latency: 1 cycle from address to rdDataX.
- Write-to-read of a different cycle: a write at edge k is visible to a read whose address is sampled at edge k+1, with data at k+2. Same-cycle reads get the value through bypass at k+1.
- busy rises at the edge that samples clearReq and stays high for exactly DEPTH cycles.
- Entry i is cleared at edge k+1+i, where k is the edge that sampled clearReq.
- The first write accepted after a clear occurs at edge k+DEPTH+1.
- Clear counter width is log2(DEPTH). It does not wrap past DEPTH-1.

## Structure
- Package reg_file_pkg holds:
  - the clear FSM state enum (IDLE, CLEAR);
  - the helper constant for address width, $clog2(DEPTH);
  - the byte-lane merge function (old, new, byteEn) -> merged.
- Sub-module register_file_clear_fsm owns the state, the counter and busy. It outputs clrEn and clrAddr to the storage array.
- The top level holds the storage array, the write merge, and the two bypass read ports.

## Test plan
- Reset then read every address on both ports: all rdData 0, busy 0.
- Write 0xDEADBEEF to entry 5 with byteEn=4'b1111, then byteEn=4'b0101 with 0x11223344: entry 5 reads 0xDE22BE44.
- Same-cycle write 0xCAFEF00D to entry 7 with A and B both reading 7: both outputs 0xCAFEF00D next cycle. With byteEn=4'b0011 over old 0xFFFFFFFF, output is 0xFFFFF00D.
- ZERO_REG=1: write 0x12345678 to address 0 with same-cycle read of 0: reads 0 with and without bypass.
- Fill all 32 entries with their index, then pulse clearReq together with a write:
  - busy is high for exactly 32 cycles and the write is dropped;
  - reading entry 31 at cycle 10 of the clear returns 31;
  - after busy falls, all entries read 0.
- Assert reset at cycle 5 of a clear: busy drops immediately and all entries are 0. A fresh clearReq then runs the full 32 cycles.
